// File: rtl/lpif_txrx_packer_if.sv
// Bundle of the LPIF-side (dstrm/ustrm) and FIFO-side (txfifo/rxfifo) signals of the packer.
// master is the packer's view; slave is the surrounding logic's view.
interface lpif_txrx_packer_if #(
    parameter int DATA_W = 512,
    parameter int CRC_W  = 16
);
    localparam int PKT_W = DATA_W + CRC_W + 9;

    logic [3:0]        dstrm_state;
    logic [1:0]        dstrm_protid;
    logic [DATA_W-1:0] dstrm_data;
    logic              dstrm_dvalid;
    logic [CRC_W-1:0]  dstrm_crc;
    logic              dstrm_crc_valid;
    logic              dstrm_valid;
    logic              dstrm_ready;

    logic [PKT_W-1:0]  txfifo_downstream_data;
    logic              txfifo_downstream_vld;
    logic              txfifo_downstream_sop;
    logic              txfifo_downstream_ready;

    logic [PKT_W-1:0]  rxfifo_upstream_data;
    logic              rxfifo_upstream_vld;
    logic              rxfifo_upstream_sop;

    logic [3:0]        ustrm_state;
    logic [1:0]        ustrm_protid;
    logic [DATA_W-1:0] ustrm_data;
    logic              ustrm_dvalid;
    logic [CRC_W-1:0]  ustrm_crc;
    logic              ustrm_crc_valid;
    logic              ustrm_valid;

    modport master (
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
               dstrm_crc, dstrm_crc_valid, dstrm_valid,
        output dstrm_ready,
        output txfifo_downstream_data, txfifo_downstream_vld, txfifo_downstream_sop,
        input  txfifo_downstream_ready,
        input  rxfifo_upstream_data, rxfifo_upstream_vld, rxfifo_upstream_sop,
        output ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
               ustrm_crc, ustrm_crc_valid, ustrm_valid
    );

    modport slave (
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
               dstrm_crc, dstrm_crc_valid, dstrm_valid,
        input  dstrm_ready,
        input  txfifo_downstream_data, txfifo_downstream_vld, txfifo_downstream_sop,
        output txfifo_downstream_ready,
        output rxfifo_upstream_data, rxfifo_upstream_vld, rxfifo_upstream_sop,
        input  ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
               ustrm_crc, ustrm_crc_valid, ustrm_valid
    );
endinterface

// File: rtl/lpif_txrx_packer.sv
// Packs LPIF flits into FIFO words (full beat in gen2, two half beats in gen1)
// and reassembles received FIFO beats back into LPIF flits.
module lpif_txrx_packer #(
    parameter int DATA_W = 512,
    parameter int CRC_W  = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 m_gen2_mode,
    lpif_txrx_packer_if.master   bus,
    output logic                 rx_align_err
);
    localparam int PKT_W  = DATA_W + CRC_W + 9;
    localparam int HALF_W = (PKT_W + 1) / 2;
    localparam int HI_W   = PKT_W - HALF_W;

    typedef enum logic [1:0] {IDLE, FULL, LO, HI} tx_state_t;

    tx_state_t        tx_state;
    logic [PKT_W-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [PKT_W-1:0] in_word;
    logic [PKT_W-1:0] next_word;
    logic [PKT_W-1:0] lo_beat;
    logic [PKT_W-1:0] hi_beat;
    logic             push;
    logic             xfer;
    logic             pop;
    logic             have_next;

    // next_word bypasses the buffer when the word being pushed this cycle is the head.
    always_comb begin
        in_word    = {bus.dstrm_valid, bus.dstrm_crc_valid, bus.dstrm_crc, bus.dstrm_dvalid,
                      bus.dstrm_data, bus.dstrm_protid, bus.dstrm_state};
        push       = bus.dstrm_valid & bus.dstrm_ready;
        xfer       = bus.txfifo_downstream_vld & bus.txfifo_downstream_ready;
        pop        = xfer & ((tx_state == FULL) | (tx_state == HI));
        count_next = count + {1'b0, push} - {1'b0, pop};
        have_next  = (count_next != 2'd0);
        next_word  = ((count - {1'b0, pop}) == 2'd0) ? in_word : buf_mem[rd_ptr ^ pop];
        lo_beat    = {{HI_W{1'b0}}, next_word[HALF_W-1:0]};
        hi_beat    = {{HALF_W{1'b0}}, buf_mem[rd_ptr][PKT_W-1:HALF_W]};
    end

    always_ff @(posedge clk_wr) begin
        if (push) begin
            buf_mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            count           <= '0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            bus.dstrm_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count           <= count_next;
            bus.dstrm_ready <= (count_next != 2'd2);
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_state                   <= IDLE;
            bus.txfifo_downstream_vld  <= 1'b0;
            bus.txfifo_downstream_sop  <= 1'b0;
            bus.txfifo_downstream_data <= '0;
        end else begin
            case (tx_state)
                IDLE, FULL, HI: begin
                    if ((tx_state == IDLE) || xfer) begin
                        if (have_next && m_gen2_mode) begin
                            tx_state                   <= FULL;
                            bus.txfifo_downstream_vld  <= 1'b1;
                            bus.txfifo_downstream_sop  <= 1'b0;
                            bus.txfifo_downstream_data <= next_word;
                        end else if (have_next) begin
                            tx_state                   <= LO;
                            bus.txfifo_downstream_vld  <= 1'b1;
                            bus.txfifo_downstream_sop  <= 1'b1;
                            bus.txfifo_downstream_data <= lo_beat;
                        end else begin
                            tx_state                  <= IDLE;
                            bus.txfifo_downstream_vld <= 1'b0;
                            bus.txfifo_downstream_sop <= 1'b0;
                        end
                    end
                end
                LO: begin
                    // Mode is deliberately not consulted: a started word always finishes in halves.
                    if (xfer) begin
                        tx_state                   <= HI;
                        bus.txfifo_downstream_sop  <= 1'b0;
                        bus.txfifo_downstream_data <= hi_beat;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    logic [HALF_W-1:0] rx_lo;
    logic              rx_lo_held;
    logic [PKT_W-1:0]  rx_word;
    logic              rx_strobe;

    always_comb begin
        rx_strobe = 1'b0;
        rx_word   = bus.rxfifo_upstream_data;
        if (bus.rxfifo_upstream_vld) begin
            if (m_gen2_mode) begin
                rx_strobe = 1'b1;
            end else if (!bus.rxfifo_upstream_sop && rx_lo_held) begin
                rx_strobe = 1'b1;
                rx_word   = {bus.rxfifo_upstream_data[HI_W-1:0], rx_lo};
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            rx_lo               <= '0;
            rx_lo_held          <= 1'b0;
            rx_align_err        <= 1'b0;
            bus.ustrm_state     <= '0;
            bus.ustrm_protid    <= '0;
            bus.ustrm_data      <= '0;
            bus.ustrm_dvalid    <= 1'b0;
            bus.ustrm_crc       <= '0;
            bus.ustrm_crc_valid <= 1'b0;
            bus.ustrm_valid     <= 1'b0;
        end else begin
            bus.ustrm_valid <= rx_strobe & rx_word[PKT_W-1];
            if (rx_strobe & rx_word[PKT_W-1]) begin
                bus.ustrm_state     <= rx_word[3:0];
                bus.ustrm_protid    <= rx_word[5:4];
                bus.ustrm_data      <= rx_word[6 +: DATA_W];
                bus.ustrm_dvalid    <= rx_word[6 + DATA_W];
                bus.ustrm_crc       <= rx_word[7 + DATA_W +: CRC_W];
                bus.ustrm_crc_valid <= rx_word[7 + DATA_W + CRC_W];
            end
            if (bus.rxfifo_upstream_vld && !m_gen2_mode) begin
                if (bus.rxfifo_upstream_sop) begin
                    rx_lo      <= bus.rxfifo_upstream_data[HALF_W-1:0];
                    rx_lo_held <= 1'b1;
                    if (rx_lo_held) begin
                        rx_align_err <= 1'b1;
                    end
                end else begin
                    rx_lo_held <= 1'b0;
                    if (!rx_lo_held) begin
                        rx_align_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lpif_txrx_packer.sv
// Scoreboard bench: accepted flits are queued and checked against txfifo beats and,
// through a txfifo->rxfifo loopback, against the reassembled ustrm flits.
`timescale 1ns/1ps
module tb_lpif_txrx_packer;
    localparam int DATA_W = 512;
    localparam int CRC_W  = 16;
    localparam int PKT_W  = DATA_W + CRC_W + 9;
    localparam int HALF_W = (PKT_W + 1) / 2;
    typedef logic [PKT_W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mode = 1'b1;
    logic rx_err;

    lpif_txrx_packer_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

    lpif_txrx_packer #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
        .clk_wr       (clk),
        .rst_wr_n     (rst_n),
        .m_gen2_mode  (mode),
        .bus          (bus),
        .rx_align_err (rx_err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned accepted = 0;
    logic edge_seen = 1'b0;
    logic mode_at_edge = 1'b1;

    word_t lo_mask;
    initial lo_mask = (word_t'(1) << HALF_W) - word_t'(1);

    // Loopback by default; direct drive for RX-only scenarios.
    logic  rx_loop = 1'b1;
    logic  rx_vld_d = 1'b0;
    logic  rx_sop_d = 1'b0;
    word_t rx_data_d = '0;
    assign bus.rxfifo_upstream_vld  = rx_loop ? (bus.txfifo_downstream_vld & bus.txfifo_downstream_ready) : rx_vld_d;
    assign bus.rxfifo_upstream_sop  = rx_loop ? bus.txfifo_downstream_sop : rx_sop_d;
    assign bus.rxfifo_upstream_data = rx_loop ? bus.txfifo_downstream_data : rx_data_d;

    logic rdy_rand = 1'b0;
    logic rdy_val = 1'b1;
    logic rdy_q = 1'b1;
    assign bus.txfifo_downstream_ready = rdy_q;
    always @(posedge clk) begin : rdy_drv
        logic r;
        r = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
        #1;
        rdy_q = r;
    end

    always @(posedge clk) begin
        cyc++;
        edge_seen = rst_n;
        mode_at_edge = mode;
    end

    task automatic chk_w(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic word_t ustrm_word();
        return {bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid,
                bus.ustrm_data, bus.ustrm_protid, bus.ustrm_state};
    endfunction

    word_t       exp_tx[$];
    int unsigned acc_cyc[$];
    word_t       exp_rx[$];
    int unsigned rx_due[$];
    int unsigned done_cyc[$];
    int          tx_phase = 0;
    logic        form_gen2 = 1'b1;
    logic        prev_vld = 1'b0;
    logic        prev_xfer = 1'b0;
    logic        prev_sop = 1'b0;
    word_t       prev_data = '0;
    word_t       drv_word = '0;

    always @(negedge clk) begin : monitor
        word_t w;
        word_t exp_d;
        logic  exp_s;
        logic  done;
        if (!rst_n) begin
            exp_tx.delete();
            acc_cyc.delete();
            exp_rx.delete();
            rx_due.delete();
            tx_phase  = 0;
            prev_vld  = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (rx_due.size() != 0 && rx_due[0] == cyc) begin
                chk_b("ustrm_valid", bus.ustrm_valid, 1'b1);
                chk_w("ustrm_word", ustrm_word(), exp_rx[0]);
                void'(exp_rx.pop_front());
                void'(rx_due.pop_front());
            end else if (bus.ustrm_valid) begin
                chk_b("ustrm_unexpected_valid", bus.ustrm_valid, 1'b0);
            end

            chk_b("dstrm_ready", bus.dstrm_ready, edge_seen && (exp_tx.size() < 2));

            if (bus.txfifo_downstream_vld) begin
                if (prev_vld && !prev_xfer) begin
                    chk_w("tx_hold_data", bus.txfifo_downstream_data, prev_data);
                    chk_b("tx_hold_sop", bus.txfifo_downstream_sop, prev_sop);
                end else if (tx_phase == 0) begin
                    form_gen2 = mode_at_edge;
                    if (!prev_vld) begin
                        if (acc_cyc.size() == 0) chk_i("tx_spurious_beat", acc_cyc.size(), 1);
                        else chk_i("tx_first_latency", cyc, acc_cyc[0] + 1);
                    end
                end
                if (bus.txfifo_downstream_ready) begin
                    if (exp_tx.size() == 0) begin
                        chk_i("tx_beat_has_word", exp_tx.size(), 1);
                    end else begin
                        w = exp_tx[0];
                        if (form_gen2) begin
                            exp_d = w; exp_s = 1'b0; done = 1'b1;
                        end else if (tx_phase == 0) begin
                            exp_d = w & lo_mask; exp_s = 1'b1; done = 1'b0;
                        end else begin
                            exp_d = w >> HALF_W; exp_s = 1'b0; done = 1'b1;
                        end
                        chk_w("tx_data", bus.txfifo_downstream_data, exp_d);
                        chk_b("tx_sop", bus.txfifo_downstream_sop, exp_s);
                        if (done) begin
                            void'(exp_tx.pop_front());
                            void'(acc_cyc.pop_front());
                            done_cyc.push_back(cyc);
                            tx_phase = 0;
                            if (rx_loop) begin
                                exp_rx.push_back(w);
                                rx_due.push_back(cyc + 1);
                            end
                        end else begin
                            tx_phase = 1;
                        end
                    end
                end
            end
            prev_vld  = bus.txfifo_downstream_vld;
            prev_xfer = bus.txfifo_downstream_vld & bus.txfifo_downstream_ready;
            prev_sop  = bus.txfifo_downstream_sop;
            prev_data = bus.txfifo_downstream_data;

            if (bus.dstrm_valid && bus.dstrm_ready) begin
                exp_tx.push_back(drv_word);
                acc_cyc.push_back(cyc);
                accepted++;
            end
        end
    end

    function automatic word_t rand_word();
        word_t w;
        for (int unsigned i = 0; i < PKT_W; i++) w[i] = 1'($urandom_range(0, 1));
        w[PKT_W-1] = 1'b1;
        return w;
    endfunction

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input word_t w);
        drv_word = w;
        bus.dstrm_state     = w[3:0];
        bus.dstrm_protid    = w[5:4];
        bus.dstrm_data      = w[6 +: DATA_W];
        bus.dstrm_dvalid    = w[6 + DATA_W];
        bus.dstrm_crc       = w[7 + DATA_W +: CRC_W];
        bus.dstrm_crc_valid = w[7 + DATA_W + CRC_W];
        bus.dstrm_valid     = 1'b1;
    endtask

    task automatic send(input word_t w);
        int unsigned n;
        drive(w);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.dstrm_ready) break;
            n++;
            if (n > 200) begin
                chk_b("dstrm_accept_timeout", bus.dstrm_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.dstrm_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_b({tag, "_dstrm_ready"}, bus.dstrm_ready, 1'b0);
        chk_b({tag, "_tx_vld"}, bus.txfifo_downstream_vld, 1'b0);
        chk_b({tag, "_tx_sop"}, bus.txfifo_downstream_sop, 1'b0);
        chk_w({tag, "_tx_data"}, bus.txfifo_downstream_data, '0);
        chk_w({tag, "_ustrm"}, ustrm_word(), '0);
        chk_b({tag, "_align_err"}, rx_err, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        word_t w, w1, w2;
        int unsigned a0;
        logic acc_now;
        bus.dstrm_valid = 1'b0;
        drive('0);
        bus.dstrm_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        cycles(2);

        // Gen2 back-to-back data=1,2,3
        mode = 1'b1;
        done_cyc.delete();
        for (int k = 1; k <= 3; k++) begin
            w = '0;
            w[6 +: DATA_W] = DATA_W'(k);
            w[PKT_W-1] = 1'b1;
            send(w);
        end
        cycles(4);
        chk_i("b2b_words_done", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk_i("b2b_gap_1", done_cyc[1] - done_cyc[0], 1);
            chk_i("b2b_gap_2", done_cyc[2] - done_cyc[1], 1);
        end

        // Gen1 single word with loopback
        mode = 1'b0;
        send(rand_word());
        cycles(6);
        chk_b("gen1_no_align_err", rx_err, 1'b0);

        // Gen2 backpressure: exactly two accepted
        mode = 1'b1;
        rdy_val = 1'b0;
        cycles(2);
        a0 = accepted;
        drive(rand_word());
        repeat (5) begin
            @(negedge clk);
            acc_now = bus.dstrm_ready;
            @(posedge clk); #1;
            if (acc_now) drive(rand_word());
        end
        chk_i("stall_accepted", accepted - a0, 2);
        chk_b("stall_ready_low", bus.dstrm_ready, 1'b0);
        bus.dstrm_valid = 1'b0;
        rdy_val = 1'b1;
        cycles(8);
        chk_i("stall_drained", exp_tx.size(), 0);

        // Gen1 word, mode flips to gen2 while LO is stalled
        rx_loop = 1'b0;
        mode = 1'b0;
        rdy_val = 1'b0;
        cycles(2);
        done_cyc.delete();
        send(rand_word());
        mode = 1'b1;
        send(rand_word());
        cycles(2);
        rdy_val = 1'b1;
        cycles(8);
        chk_i("modeflip_drained", exp_tx.size(), 0);
        chk_i("modeflip_words", done_cyc.size(), 2);
        rx_loop = 1'b1;
        cycles(1);

        // Random traffic, gen2 then gen1
        for (int m = 1; m >= 0; m--) begin
            mode = 1'(m);
            rdy_rand = 1'b1;
            repeat (35) begin
                send(rand_word());
                cycles($urandom_range(0, 2));
            end
            rdy_rand = 1'b0;
            rdy_val = 1'b1;
            cycles(10);
            chk_i("rand_tx_drained", exp_tx.size(), 0);
            chk_i("rand_rx_drained", exp_rx.size(), 0);
        end
        chk_b("rand_no_align_err", rx_err, 1'b0);

        // RX gen1: orphan high half, then a proper pair
        rx_loop = 1'b0;
        mode = 1'b0;
        cycles(1);
        rx_data_d = rand_word(); rx_sop_d = 1'b0; rx_vld_d = 1'b1;
        cycles(1);
        rx_vld_d = 1'b0;
        cycles(3);
        chk_b("orphan_align_err", rx_err, 1'b1);
        chk_b("orphan_no_valid", bus.ustrm_valid, 1'b0);
        w = rand_word();
        rx_data_d = w & lo_mask; rx_sop_d = 1'b1; rx_vld_d = 1'b1;
        cycles(1);
        rx_data_d = w >> HALF_W; rx_sop_d = 1'b0;
        exp_rx.push_back(w);
        rx_due.push_back(cyc + 1);
        cycles(1);
        rx_vld_d = 1'b0;
        cycles(3);
        chk_b("align_err_sticky", rx_err, 1'b1);

        // Reset while in HI with two entries held
        rdy_val = 1'b0;
        cycles(2);
        w1 = rand_word();
        w2 = rand_word();
        send(w1);
        send(w2);
        rdy_val = 1'b1;
        cycles(1);
        rdy_val = 1'b0;
        cycles(2);
        chk_i("pre_reset_held", exp_tx.size(), 2);
        chk_b("pre_reset_sop_hi", bus.txfifo_downstream_sop, 1'b0);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        cycles(6);
        chk_b("post_reset_no_beat", bus.txfifo_downstream_vld, 1'b0);
        chk_b("post_reset_ready", bus.dstrm_ready, 1'b1);
        chk_b("post_reset_align_err", rx_err, 1'b0);
        rx_loop = 1'b1;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
